// File: rtl/otsu_pkg.sv
// Shared widths for the Otsu threshold stage; all products are kept full width.
// Pure constants: no latency, no flow control.
package otsu_pkg;
  localparam int NBIN    = 128;
  localparam int N_W     = 20;
  localparam int G_W     = 23;
  localparam int T_W     = 7;
  localparam int PROD_W  = N_W + G_W;
  localparam int NUM_W   = 2 * PROD_W;
  localparam int DEN_W   = 2 * N_W;
  localparam int XPROD_W = NUM_W + DEN_W;
endpackage

// File: rtl/otsu_var_cmp.sv
// Cross-multiplied variance compare (num/den vs bnum/bden); strict greater-than.
// One registered cycle; no backpressure, a result every cycle.
module otsu_var_cmp
  import otsu_pkg::*;
(
  input  logic               clock,
  input  logic               rst,
  input  logic [NUM_W-1:0]   num,
  input  logic [DEN_W-1:0]   den,
  input  logic [NUM_W-1:0]   bnum,
  input  logic [DEN_W-1:0]   bden,
  output logic               better
);

  logic [XPROD_W-1:0] lhs, rhs;

  assign lhs = XPROD_W'(num) * XPROD_W'(bden);
  assign rhs = XPROD_W'(bnum) * XPROD_W'(den);

  always_ff @(posedge clock) begin
    if (rst) better <= 1'b0;
    else     better <= (lhs > rhs);
  end

endmodule

// File: rtl/otsu_thresh.sv
// Divider-free Otsu threshold search over 128 candidate class sums per frame.
// Strobe to thresh_vld is 6 cycles; no backpressure, strobes must be >= 6 cycles apart.
module otsu_thresh
  import otsu_pkg::*;
(
  input  logic             clock,
  input  logic             rst,
  input  logic             dsp_vld,
  input  logic [N_W-1:0]   N1,
  input  logic [N_W-1:0]   N2,
  input  logic [G_W-1:0]   GrayAll1,
  input  logic [G_W-1:0]   GrayAll2,
  input  logic             finish_clear,
  output logic [7:0]       thresh,
  output logic             thresh_vld,
  output logic             frame_err
);

  logic [T_W-1:0]    k;
  logic              accept, abort, degen, better;

  logic              v1, v2, v3, v4, last1, last2, last3, last4, last5, degen1;
  logic [T_W-1:0]    k1, k2, k3, k4;
  logic [PROD_W-1:0] p1_q, p2_q, absd2;
  logic [DEN_W-1:0]  den1, den2, den3, den4;
  logic [NUM_W-1:0]  num3, num4;

  logic [NUM_W-1:0]  bnum;
  logic [DEN_W-1:0]  bden;
  logic [T_W-1:0]    bt;

  // finish_clear always takes priority over a coincident strobe
  assign accept = dsp_vld & ~finish_clear;
  assign abort  = finish_clear & (k != '0);
  assign degen  = (N1 == '0) || (N2 == '0);

  always_ff @(posedge clock) begin
    p1_q   <= PROD_W'(N2) * PROD_W'(GrayAll1);
    p2_q   <= PROD_W'(N1) * PROD_W'(GrayAll2);
    den1   <= degen ? DEN_W'(1) : DEN_W'(N1) * DEN_W'(N2);
    degen1 <= degen;
    k1     <= k;
    last1  <= (k == T_W'(NBIN - 1));

    absd2  <= degen1 ? '0 : ((p1_q >= p2_q) ? (p1_q - p2_q) : (p2_q - p1_q));
    den2   <= den1;
    k2     <= k1;
    last2  <= last1;

    num3   <= NUM_W'(absd2) * NUM_W'(absd2);
    den3   <= den2;
    k3     <= k2;
    last3  <= last2;

    num4   <= num3;
    den4   <= den3;
    k4     <= k3;
    last4  <= last3;
  end

  otsu_var_cmp u_cmp (
    .clock  (clock),
    .rst    (rst),
    .num    (num3),
    .den    (den3),
    .bnum   (bnum),
    .bden   (bden),
    .better (better)
  );

  always_ff @(posedge clock) begin
    if (rst) begin
      k          <= '0;
      v1         <= 1'b0;
      v2         <= 1'b0;
      v3         <= 1'b0;
      v4         <= 1'b0;
      last5      <= 1'b0;
      bnum       <= '0;
      bden       <= DEN_W'(1);
      bt         <= '0;
      thresh     <= '0;
      thresh_vld <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      v1         <= accept;
      v2         <= v1;
      v3         <= v2;
      v4         <= v3;
      last5      <= v4 & last4;
      thresh_vld <= last5;
      frame_err  <= abort;
      if (last5) thresh <= {1'b0, bt};

      if (abort)       k <= '0;
      else if (accept) k <= k + 1'b1;

      // best registers restart for the next frame on emit or abort
      if (last5 || abort) begin
        bnum <= '0;
        bden <= DEN_W'(1);
        bt   <= '0;
      end else if (v4 && better) begin
        bnum <= num4;
        bden <= den4;
        bt   <= k4;
      end

      // in-flight samples of an aborted frame must not touch the next one
      if (abort) begin
        v2    <= 1'b0;
        v3    <= 1'b0;
        v4    <= 1'b0;
        last5 <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_otsu_thresh.sv
// Bench for otsu_thresh: frame tables, abort/reset sequences and random frames vs a reference model.
module tb_otsu_thresh;

  localparam int NB = 128;

  logic        clock = 1'b0;
  logic        rst = 1'b1;
  logic        dsp_vld = 1'b0;
  logic [19:0] N1 = '0, N2 = '0;
  logic [22:0] GrayAll1 = '0, GrayAll2 = '0;
  logic        finish_clear = 1'b0;
  logic [7:0]  thresh;
  logic        thresh_vld, frame_err;

  otsu_thresh dut (
    .clock        (clock),
    .rst          (rst),
    .dsp_vld      (dsp_vld),
    .N1           (N1),
    .N2           (N2),
    .GrayAll1     (GrayAll1),
    .GrayAll2     (GrayAll2),
    .finish_clear (finish_clear),
    .thresh       (thresh),
    .thresh_vld   (thresh_vld),
    .frame_err    (frame_err)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int vld_cnt = 0;
  int err_cnt = 0;

  always @(negedge clock) begin
    if (thresh_vld) vld_cnt++;
    if (frame_err)  err_cnt++;
  end

  logic [19:0] n1_a [NB];
  logic [19:0] n2_a [NB];
  logic [22:0] g1_a [NB];
  logic [22:0] g2_a [NB];
  int          hist [NB];

  typedef struct {
    int ga; int ca; int gb; int cb; int exp_t;
  } fvec_t;
  fvec_t tbl [5];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask

  // class sums straight from a histogram: class 1 is gray <= t
  function automatic void build_from_hist();
    longint tot_n = 0, tot_g = 0, c = 0, g = 0;
    for (int t = 0; t < NB; t++) begin
      tot_n += hist[t];
      tot_g += longint'(t) * hist[t];
    end
    for (int t = 0; t < NB; t++) begin
      c += hist[t];
      g += longint'(t) * hist[t];
      n1_a[t] = 20'(c);
      n2_a[t] = 20'(tot_n - c);
      g1_a[t] = 23'(g);
      g2_a[t] = 23'(tot_g - g);
    end
  endfunction

  function automatic void build_bimodal(input int ga, input int ca, input int gb, input int cb);
    for (int t = 0; t < NB; t++) hist[t] = 0;
    hist[ga] += ca;
    hist[gb] += cb;
    build_from_hist();
  endfunction

  // argmax of D^2/(N1*N2) with exact rational compare; first maximum wins
  function automatic int ref_thresh();
    logic [127:0] num, den, bn, bd;
    longint d;
    int best = 0;
    bn = 0;
    bd = 1;
    for (int t = 0; t < NB; t++) begin
      if (n1_a[t] == 0 || n2_a[t] == 0) continue;
      d = longint'(n2_a[t]) * longint'(g1_a[t]) - longint'(n1_a[t]) * longint'(g2_a[t]);
      if (d < 0) d = -d;
      num = 128'(d) * 128'(d);
      den = 128'(n1_a[t]) * 128'(n2_a[t]);
      if (num * bd > bn * den) begin
        bn = num;
        bd = den;
        best = t;
      end
    end
    return best;
  endfunction

  task automatic feed(input int nstb);
    for (int k = 0; k < nstb; k++) begin
      @(posedge clock); #1;
      dsp_vld = 1'b1;
      N1 = n1_a[k]; N2 = n2_a[k];
      GrayAll1 = g1_a[k]; GrayAll2 = g2_a[k];
      @(posedge clock); #1;
      dsp_vld = 1'b0;
      if (k != nstb - 1) repeat (5) @(posedge clock);
    end
  endtask

  task automatic play_frame(input string nm, input int exp_t);
    int vc0, ec0;
    vc0 = vld_cnt;
    ec0 = err_cnt;
    feed(NB);
    repeat (4) @(posedge clock); #1;
    chk({nm, "_vld_early"}, thresh_vld, 0);
    chk({nm, "_no_pulse_in_frame"}, vld_cnt - vc0, 0);
    @(posedge clock); #1;
    chk({nm, "_vld_t6"}, thresh_vld, 1);
    chk({nm, "_thresh"}, thresh, exp_t);
    repeat (3) @(posedge clock); #1;
    chk({nm, "_one_pulse"}, vld_cnt - vc0, 1);
    chk({nm, "_held"}, thresh, exp_t);
    chk({nm, "_no_err"}, err_cnt - ec0, 0);
  endtask

  initial begin
    int vc0, ec0, exp_r;

    tbl[0] = '{20, 512, 100, 512, 20};
    tbl[1] = '{50, 1024, 0, 0, 0};
    tbl[2] = '{30, 600, 100, 424, 30};
    tbl[3] = '{30, 200, 70, 824, 30};
    tbl[4] = '{77, 1000, 120, 24, 77};

    repeat (3) @(posedge clock); #1;
    rst = 1'b0;
    chk("reset_thresh", thresh, 0);
    chk("reset_vld", thresh_vld, 0);
    chk("reset_err", frame_err, 0);

    for (int i = 0; i < 5; i++) begin
      build_bimodal(tbl[i].ga, tbl[i].ca, tbl[i].gb, tbl[i].cb);
      play_frame($sformatf("tbl%0d", i), tbl[i].exp_t);
    end

    // full-width stress: k=11 beats k=10 by one in |D|, k=12 ties k=11
    for (int t = 0; t < NB; t++) begin
      n1_a[t] = '0; n2_a[t] = 20'hFFFFF; g1_a[t] = '0; g2_a[t] = 23'h7FFFFF;
    end
    n1_a[10] = 20'h80000; n2_a[10] = 20'h7FFFF; g1_a[10] = 23'h7FFFFF; g2_a[10] = 23'd1;
    for (int t = 11; t <= 12; t++) begin
      n1_a[t] = 20'h80000; n2_a[t] = 20'h7FFFF; g1_a[t] = 23'h7FFFFE; g2_a[t] = 23'd0;
    end
    play_frame("stress", 11);

    for (int r = 0; r < 3; r++) begin
      for (int t = 0; t < NB; t++) hist[t] = 0;
      for (int p = 0; p < 4; p++) hist[$urandom_range(0, NB - 1)] += $urandom_range(1, 2000);
      build_from_hist();
      exp_r = ref_thresh();
      play_frame($sformatf("rand%0d", r), exp_r);
    end

    // reset in the middle of a frame
    build_bimodal(40, 512, 90, 512);
    vc0 = vld_cnt;
    ec0 = err_cnt;
    feed(60);
    rst = 1'b1;
    repeat (2) @(posedge clock); #1;
    rst = 1'b0;
    chk("midrst_thresh", thresh, 0);
    chk("midrst_vld", thresh_vld, 0);
    repeat (10) @(posedge clock); #1;
    chk("midrst_no_pulse", vld_cnt - vc0, 0);
    chk("midrst_no_err", err_cnt - ec0, 0);
    play_frame("after_rst", 40);

    // incomplete frame aborted by finish_clear
    build_bimodal(30, 512, 100, 512);
    feed(100);
    repeat (8) @(posedge clock); #1;
    vc0 = vld_cnt;
    ec0 = err_cnt;
    finish_clear = 1'b1;
    @(posedge clock); #1;
    finish_clear = 1'b0;
    chk("abort_err_pulse", frame_err, 1);
    @(posedge clock); #1;
    chk("abort_err_one_cycle", frame_err, 0);
    repeat (8) @(posedge clock); #1;
    chk("abort_no_vld", vld_cnt - vc0, 0);
    chk("abort_err_count", err_cnt - ec0, 1);
    chk("abort_thresh_held", thresh, 40);
    build_bimodal(77, 300, 120, 300);
    play_frame("after_abort", 77);

    // finish_clear at a frame boundary with a coincident strobe: no error, sample dropped
    @(posedge clock); #1;
    finish_clear = 1'b1;
    dsp_vld = 1'b1;
    N1 = 20'd5; N2 = 20'd5; GrayAll1 = 23'd5; GrayAll2 = 23'd500;
    @(posedge clock); #1;
    finish_clear = 1'b0;
    dsp_vld = 1'b0;
    chk("bound_fc_no_err", frame_err, 0);
    repeat (6) @(posedge clock); #1;
    build_bimodal(20, 512, 100, 512);
    play_frame("after_bound_fc", 20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
